// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: converts a cmd/rsp handshake into one
// AXI4-Lite read or write and reports the slave response and latency.
module axi4_lite_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [CNT_W-1:0]  rsp_cycles,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [DATA_W-1:0] M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t              state, state_nxt;
    logic                cmd_ready_nxt;
    logic                rsp_valid_nxt;
    logic [DATA_W-1:0]   rsp_rdata_nxt;
    logic [1:0]          rsp_resp_nxt;
    logic [CNT_W-1:0]    rsp_cycles_nxt;
    logic [CNT_W-1:0]    cycles_inc;
    logic [ADDR_W-1:0]   awaddr_nxt, araddr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [3:0]          wstrb_nxt;
    logic                awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
    logic                aw_done, w_done;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            rsp_cycles    <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cmd_ready     <= cmd_ready_nxt;
            rsp_valid     <= rsp_valid_nxt;
            rsp_rdata     <= rsp_rdata_nxt;
            rsp_resp      <= rsp_resp_nxt;
            rsp_cycles    <= rsp_cycles_nxt;
            M_AXI_AWADDR  <= awaddr_nxt;
            M_AXI_AWVALID <= awvalid_nxt;
            M_AXI_WDATA   <= wdata_nxt;
            M_AXI_WSTRB   <= wstrb_nxt;
            M_AXI_WVALID  <= wvalid_nxt;
            M_AXI_BREADY  <= bready_nxt;
            M_AXI_ARADDR  <= araddr_nxt;
            M_AXI_ARVALID <= arvalid_nxt;
            M_AXI_RREADY  <= rready_nxt;
        end
    end

    // Saturating latency count; every non-IDLE/RSP state has a VALID or READY up.
    assign cycles_inc = (&rsp_cycles) ? rsp_cycles : rsp_cycles + 1'b1;
    assign aw_done    = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_done     = !M_AXI_WVALID  || M_AXI_WREADY;

    always_comb begin
        state_nxt      = state;
        cmd_ready_nxt  = cmd_ready;
        rsp_valid_nxt  = rsp_valid;
        rsp_rdata_nxt  = rsp_rdata;
        rsp_resp_nxt   = rsp_resp;
        rsp_cycles_nxt = rsp_cycles;
        awaddr_nxt     = M_AXI_AWADDR;
        awvalid_nxt    = M_AXI_AWVALID;
        wdata_nxt      = M_AXI_WDATA;
        wstrb_nxt      = M_AXI_WSTRB;
        wvalid_nxt     = M_AXI_WVALID;
        bready_nxt     = M_AXI_BREADY;
        araddr_nxt     = M_AXI_ARADDR;
        arvalid_nxt    = M_AXI_ARVALID;
        rready_nxt     = M_AXI_RREADY;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_nxt  = 1'b0;
                    rsp_cycles_nxt = '0;
                    if (cmd_write) begin
                        state_nxt   = WR_REQ;
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD_REQ;
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                rsp_cycles_nxt = cycles_inc;
                if (M_AXI_AWVALID && M_AXI_AWREADY) awvalid_nxt = 1'b0;
                if (M_AXI_WVALID && M_AXI_WREADY)   wvalid_nxt  = 1'b0;
                if (aw_done && w_done) begin
                    state_nxt  = WR_RESP;
                    bready_nxt = 1'b1;
                end
            end
            WR_RESP: begin
                rsp_cycles_nxt = cycles_inc;
                if (M_AXI_BVALID) begin
                    rsp_resp_nxt  = M_AXI_BRESP;
                    rsp_rdata_nxt = '0;
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RSP;
                end
            end
            RD_REQ: begin
                rsp_cycles_nxt = cycles_inc;
                if (M_AXI_ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_RESP;
                end
            end
            RD_RESP: begin
                rsp_cycles_nxt = cycles_inc;
                if (M_AXI_RVALID) begin
                    rsp_resp_nxt  = M_AXI_RRESP;
                    rsp_rdata_nxt = M_AXI_RDATA;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: a cycle-level slave driven from tasks,
// with expected responses and latencies derived from the handshake rules.
module tb_axi4_lite_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] rsp_cycles;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [DW-1:0] wdata, rdata = '0;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = '0, rresp = '0;
    logic          bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic          rvalid = 1'b0, rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_lite_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    function automatic int eff(input int lat);
        return (lat == 0) ? 1 : lat;
    endfunction

    // Latency = request-phase cycles + response wait cycles + handshake cycle, clipped.
    function automatic int exp_cycles(input logic wr, input int aw_l, input int w_l,
                                      input int ar_l, input int rd);
        int raw;
        int sat;
        raw = wr ? (((eff(aw_l) > eff(w_l)) ? eff(aw_l) : eff(w_l)) + rd + 1)
                 : (eff(ar_l) + rd + 1);
        sat = (1 << CW) - 1;
        return (raw > sat) ? sat : raw;
    endfunction

    task automatic idle_slave();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = '0; rresp = '0; rdata = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input string nm, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [3:0] st,
                          input int aw_l, input int w_l, input int ar_l, input int rd,
                          input logic [DW-1:0] sdata, input logic [1:0] sresp, input int hold);
        int awc = 0, wc = 0, arc = 0, bc = 0, rc = 0;
        int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
        int viol = 0, stab = 0, hviol = 0, seen = 0, cyc = 0;
        bit done = 0, first = 1;
        logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
        logic p_bv = 0, p_br = 0, p_rv = 0, p_rr = 0, p_sv = 0, p_sr = 0;
        logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
        logic [DW-1:0] p_wdata = '0, r0_d = '0;
        logic [3:0]    p_wstrb = '0;
        logic [1:0]    r0_r = '0;
        logic [CW-1:0] r0_c = '0;
        logic [DW-1:0] exp_d;
        int            exp_c;

        exp_d = wr ? '0 : sdata;
        exp_c = exp_cycles(wr, aw_l, w_l, ar_l, rd);

        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL %s idle_ready: cmd_ready=%b required 1", nm, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        awready = wr && (aw_l == 0);
        wready  = wr && (w_l == 0);
        arready = !wr && (ar_l == 0);
        bvalid  = !wr;
        rvalid  = wr;
        bresp   = sresp; rresp = sresp; rdata = wr ? DW'($urandom) : sdata;

        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                first = 0;
                total++;
                if (cmd_ready !== 1'b0 ||
                    (wr ? !(awvalid && wvalid && !arvalid) : !(arvalid && !awvalid && !wvalid))) begin
                    bad++;
                    $display("FAIL %s accept: ready=%b aw=%b w=%b ar=%b required ready=0 valids for wr=%b",
                             nm, cmd_ready, awvalid, wvalid, arvalid, wr);
                end
                total++;
                if (wr ? (awaddr !== addr || wdata !== wd || wstrb !== st) : (araddr !== addr)) begin
                    bad++;
                    $display("FAIL %s payload: awaddr=%h wdata=%h wstrb=%h araddr=%h required addr=%h data=%h strb=%h",
                             nm, awaddr, wdata, wstrb, araddr, addr, wd, st);
                end
            end
            // Junk command while busy must be ignored.
            if (!done) begin
                cmd_valid = 1'b1; cmd_write = $urandom_range(0, 1);
                cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom); cmd_wstrb = 4'($urandom);
            end

            if (p_awv && p_awr) aw_hs++;
            if (p_wv && p_wr)   w_hs++;
            if (p_arv && p_arr) ar_hs++;
            if (p_bv && p_br)   b_hs++;
            if (p_rv && p_rr)   r_hs++;

            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) viol++;
            if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) viol++;
            if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) viol++;
            if (wr && (arvalid || rready)) viol++;
            if (!wr && (awvalid || wvalid || bready)) viol++;

            if (p_sv && p_sr) begin
                done = 1;
                cmd_valid = 1'b0;
                total++;
                if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL %s release: rsp_valid=%b cmd_ready=%b required 0/1", nm, rsp_valid, cmd_ready);
                end
            end else if (rsp_valid) begin
                if (seen == 0) begin
                    r0_d = rsp_rdata; r0_r = rsp_resp; r0_c = rsp_cycles;
                    total++;
                    if (rsp_rdata !== exp_d) begin
                        bad++; $display("FAIL %s rdata: got %h required %h", nm, rsp_rdata, exp_d);
                    end
                    total++;
                    if (rsp_resp !== sresp) begin
                        bad++; $display("FAIL %s resp: got %b required %b", nm, rsp_resp, sresp);
                    end
                    total++;
                    if (rsp_cycles !== CW'(exp_c)) begin
                        bad++; $display("FAIL %s cycles: got %0d required %0d", nm, rsp_cycles, exp_c);
                    end
                end else if (rsp_rdata !== r0_d || rsp_resp !== r0_r || rsp_cycles !== r0_c) begin
                    stab++;
                end
                if (cmd_ready || awvalid || wvalid || arvalid || bready || rready) hviol++;
                seen++;
                rsp_ready = (seen > hold);
            end

            if (awvalid) awc++;
            if (wvalid)  wc++;
            if (arvalid) arc++;
            if (wr) begin
                awready = (aw_l == 0) ? (aw_hs == 0) : (awvalid && awc >= aw_l);
                wready  = (w_l == 0)  ? (w_hs == 0)  : (wvalid && wc >= w_l);
                if (bready) bc++;
                bvalid = bready && (bc > rd);
                rdata  = DW'($urandom);
            end else begin
                arready = (ar_l == 0) ? (ar_hs == 0) : (arvalid && arc >= ar_l);
                if (rready) rc++;
                rvalid = rready && (rc > rd);
            end

            p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            p_arv = arvalid; p_arr = arready; p_bv = bvalid; p_br = bready;
            p_rv = rvalid; p_rr = rready; p_sv = rsp_valid; p_sr = rsp_ready;
            p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_wstrb = wstrb;
        end
        cmd_valid = 1'b0;
        idle_slave();

        total++;
        if (!done) begin
            bad++; $display("FAIL %s timeout: response not consumed after %0d cycles required completion", nm, cyc);
        end
        total++;
        if (viol != 0) begin
            bad++; $display("FAIL %s protocol: violations=%0d required 0", nm, viol);
        end
        total++;
        if (wr ? (aw_hs != 1 || w_hs != 1 || b_hs != 1 || ar_hs != 0 || r_hs != 0)
               : (ar_hs != 1 || r_hs != 1 || aw_hs != 0 || w_hs != 0 || b_hs != 0)) begin
            bad++;
            $display("FAIL %s handshakes: aw=%0d w=%0d b=%0d ar=%0d r=%0d required one per used channel",
                     nm, aw_hs, w_hs, b_hs, ar_hs, r_hs);
        end
        total++;
        if (stab != 0 || hviol != 0 || seen != hold + 1) begin
            bad++;
            $display("FAIL %s rsp_hold: unstable=%0d busy_violations=%0d valid_cycles=%0d required 0/0/%0d",
                     nm, stab, hviol, seen, hold + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_resp !== '0 ||
            rsp_cycles !== '0 || awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 ||
            arvalid !== 1'b0 || rready !== 1'b0 || awaddr !== '0 || araddr !== '0 ||
            wdata !== '0 || wstrb !== '0) begin
            bad++;
            $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b aw=%b w=%b b=%b ar=%b r=%b awaddr=%h required idle zeros",
                     cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, awaddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        do_txn("write_basic", 1'b1, 32'h7C80_0000, 32'h0000_000A, 4'hF, 2, 2, 0, 0, '0, 2'b00, 0);
    endtask

    task automatic test_write_skew();
        do_txn("write_skew", 1'b1, 32'h7C80_0004, 32'hDEAD_BEEF, 4'h5, 1, 4, 0, 1, '0, 2'b00, 1);
    endtask

    task automatic test_read();
        do_txn("read_basic", 1'b0, 32'h7C80_0010, '0, 4'h0, 0, 0, 1, 2, 32'h0000_0002, 2'b00, 0);
    endtask

    task automatic test_read_err_hold();
        do_txn("read_slverr", 1'b0, 32'h7C80_0018, '0, 4'h0, 0, 0, 2, 1, 32'hCAFE_F00D, 2'b10, 5);
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_write", 1'b1, 32'h7C80_000C, 32'h0000_0001, 4'hF, 1, 1, 0, 0, '0, 2'b00, 0);
        do_txn("b2b_read", 1'b0, 32'h7C80_0014, '0, 4'h0, 0, 0, 1, 0, 32'h1234_5678, 2'b00, 0);
    endtask

    task automatic test_saturation();
        do_txn("saturate", 1'b1, 32'h7C80_0020, 32'h5555_AAAA, 4'h3, 10, 3, 0, 8, '0, 2'b11, 2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h7C80_0008;
        cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            bad++; $display("FAIL reset_mid_pre: aw=%b w=%b required 1/1", awvalid, wvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || arvalid !== 1'b0 ||
            rready !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || awaddr !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: aw=%b w=%b b=%b ar=%b r=%b rsp_valid=%b cmd_ready=%b awaddr=%h required zeros and ready=1",
                     awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready, awaddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_txn("after_reset", 1'b1, 32'h7C80_0008, 32'h0000_0077, 4'hC, 1, 2, 0, 1, '0, 2'b00, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            do_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                   32'h7C80_0000 | (AW'($urandom_range(0, 63)) << 2), DW'($urandom), 4'($urandom),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 6)), DW'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_skew();
        test_read();
        test_read_err_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response interface into AXI4-Lite read and write transactions.
- Used as the initiator that drives the PTB2 AXI4-Lite slave peripherals (register base 0x7C800000) from bench sequencers or a local controller.
- Also reports the slave's response code and the per-transaction cycle count.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; fixed at 32 for AXI4-Lite.
- CNT_W, 16, width of the latency counter rsp_cycles; the counter saturates at all-ones.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 after a write)
- rsp_resp  out  2  captured BRESP/RRESP
- rsp_cycles  out  CNT_W  cycles from the first VALID to the B/R handshake
- M_AXI_AWADDR  out  ADDR_W
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DATA_W
- M_AXI_WSTRB  out  4
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_W
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA_W
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- One clock, M_AXI_ACLK; reset is asynchronous and active-low on M_AXI_ARESETN.
- All outputs are registered.
- Reset values:
  - cmd_ready = 1.
  - All AXI VALID/READY outputs = 0.
  - AWADDR, ARADDR, WDATA, WSTRB = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_cycles = 0; FSM in IDLE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch the command and drop cmd_ready next cycle.
  - Write command → WR_REQ, with AWVALID = WVALID = 1 and the address/data/strobe driven from the following cycle.
  - Read command → RD_REQ, with ARVALID = 1.
- WR_REQ:
  - AWVALID and WVALID are each held until their own handshake, then cleared independently; both may complete in the same cycle.
  - AWADDR, WDATA and WSTRB are stable while the corresponding VALID is high.
  - When both handshakes are done → WR_RESP, with BREADY = 1.
- WR_RESP:
  - On BVALID && BREADY: capture BRESP into rsp_resp, set rsp_rdata = 0, set BREADY = 0 → RSP.
- RD_REQ:
  - ARVALID held until ARREADY; then ARVALID = 0 → RD_RESP, with RREADY = 1.
- RD_RESP:
  - On RVALID && RREADY: capture RDATA and RRESP, set RREADY = 0 → RSP.
- RSP:
  - rsp_valid = 1; rsp_rdata, rsp_resp and rsp_cycles are stable.
  - On rsp_ready: rsp_valid = 0, cmd_ready = 1 → IDLE.
  - The minimum gap between accepted commands is one IDLE cycle.
- VALID rules:
  - No VALID is ever deasserted before its handshake.
  - VALIDs never depend combinationally on READYs.
- rsp_cycles:
  - Cleared on command acceptance.
  - Increments every cycle from the first VALID cycle through the B/R handshake cycle inclusive; saturates at all-ones.
- cmd_* inputs are ignored outside IDLE.
- A slave READY arriving before VALID is tolerated.
- BVALID/RVALID outside WR_RESP/RD_RESP is ignored, with READY held at 0.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous), the FSM goes to IDLE, and the in-flight command is lost with no response.
- Non-OKAY BRESP/RRESP values are passed through unchanged; no retry.

Test Plan:
- Write cmd addr 0x7C800000, data 0x0000000A, strobe 0xF, slave AW/W ready on the 2nd VALID cycle:
  - AWVALID and WVALID high together until the handshake.
  - BREADY high, BRESP = 00.
  - rsp_valid with rsp_resp = 00, rsp_rdata = 0, rsp_cycles = 3.
- Write where AWREADY arrives 3 cycles before WREADY:
  - AWVALID drops after its handshake; WVALID is held with WDATA stable.
  - Exactly one B handshake follows.
- Read of 0x7C800010 with the slave returning RDATA = 0x00000002, RRESP = 00 after 2 wait cycles:
  - rsp_rdata = 0x2, rsp_resp = 00.
  - ARVALID is high only until ARREADY.
- Read returning RRESP = 10, and rsp_ready held low for 5 cycles:
  - rsp_valid stays high with data stable.
  - cmd_ready stays 0 and no new AXI VALID appears until rsp_ready.
- Back-to-back write 0x7C80000C data 1, then read 0x7C800014:
  - Second command is accepted only after the first response is consumed.
  - Transactions are ordered; there is no overlap on the AW/AR channels.
- Assert M_AXI_ARESETN low while in WR_REQ:
  - All VALID/READY outputs go 0 asynchronously, with no clock edge needed.
  - After release, cmd_ready = 1 and the next command completes normally.
